// File: rtl/fpsub_pipe_pkg.sv
// Shared FP32 field layout and datapath widths for the fpsub_pipe subtractor.
// FPSUB_ROUND_EN widens the significand path by guard/round/sticky bits.
package fpsub_pipe_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS  = 127;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

`ifdef FPSUB_ROUND_EN
    localparam int EXT_W = 3;
`else
    localparam int EXT_W = 0;
`endif

    // Aligned significand (hidden one + mantissa + extension) and its sum with carry.
    localparam int SIG_W = FP32_MAN_W + 1 + EXT_W;
    localparam int SUM_W = SIG_W + 1;

    function automatic logic fp32_is_zero(input fp32_t v);
        return v.exp == '0;
    endfunction

endpackage

// File: rtl/fpsub_pipe_if.sv
// Request/response handshake bundle for fpsub_pipe: the producer/consumer side
// uses the master modport, the subtractor uses the slave modport.
interface fpsub_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] reg_A;
    logic [31:0] reg_B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    modport master (
        output in_valid, reg_A, reg_B, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, reg_A, reg_B, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/fpsub_normalize.sv
// Final stage of fpsub_pipe: leading-zero normalize, exponent adjust and pack.
// With FPSUB_ROUND_EN defined it also rounds to nearest-even and renormalizes.
module fpsub_normalize
    import fpsub_pipe_pkg::*;
(
    input  logic [SUM_W-1:0]      i_sum,
    input  logic [FP32_EXP_W-1:0] i_exp,
    input  logic                  i_sign,
    output logic [31:0]           o_result
);
    localparam int LZ_W = 5;

    logic [LZ_W-1:0]       w_lz;
    logic [SIG_W-1:0]      w_m;
    logic [FP32_EXP_W-1:0] w_e;
    logic [FP32_MAN_W-1:0] w_man;
    logic [FP32_EXP_W-1:0] w_e_fin;

    // Highest set bit wins because it is visited last.
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < SIG_W; i++) begin
            if (i_sum[i]) w_lz = LZ_W'(SIG_W - 1 - i);
        end
    end

    always_comb begin
        w_m = '0;
        w_e = i_exp;
        if (i_sum[SUM_W-1]) begin
`ifdef FPSUB_ROUND_EN
            w_m = {i_sum[SUM_W-1:2], |i_sum[1:0]};
`else
            w_m = i_sum[SUM_W-1:1];
`endif
            w_e = i_exp + 8'd1;
        end else begin
            w_m = i_sum[SIG_W-1:0] << w_lz;
            w_e = i_exp - FP32_EXP_W'(w_lz);
        end
    end

`ifdef FPSUB_ROUND_EN
    logic                  w_inc;
    logic [FP32_MAN_W+1:0] w_rnd;

    // w_m[3] is the kept LSB, [2:0] are guard/round/sticky.
    assign w_inc   = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    assign w_rnd   = {1'b0, w_m[SIG_W-1:EXT_W]} + {{(FP32_MAN_W+1){1'b0}}, w_inc};
    assign w_man   = w_rnd[FP32_MAN_W+1] ? w_rnd[FP32_MAN_W:1] : w_rnd[FP32_MAN_W-1:0];
    assign w_e_fin = w_e + {{(FP32_EXP_W-1){1'b0}}, w_rnd[FP32_MAN_W+1]};
`else
    assign w_man   = w_m[FP32_MAN_W-1:0];
    assign w_e_fin = w_e;
`endif

    // A clear leading bit after normalization only happens for an all-zero sum.
    assign o_result = w_m[SIG_W-1] ? {i_sign, w_e_fin, w_man} : 32'h0000_0000;

endmodule

// File: rtl/fpsub_pipe.sv
// Three-stage FP32 subtractor (out = A - B) with a global valid/ready stall.
// FPSUB_ROUND_EN selects round-to-nearest-even; otherwise the result is truncated.
module fpsub_pipe
    import fpsub_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    fpsub_pipe_if.slave bus
);
    logic                  w_adv;
    fp32_t                 w_a;
    fp32_t                 w_bn;
    fp32_t                 w_x;
    fp32_t                 w_y;
    logic                  w_a_zero;
    logic                  w_b_zero;
    logic                  w_a_ge;
    logic [FP32_EXP_W-1:0] w_diff;
    logic [FP32_MAN_W:0]   w_x_sig24;
    logic [FP32_MAN_W:0]   w_y_sig24;
    logic [SIG_W-1:0]      w_sig_x;
    logic [SIG_W-1:0]      w_sig_y;
    logic [SUM_W-1:0]      w_sum;
    logic [31:0]           w_norm;

    logic                  r1_valid, r1_special, r1_sign, r1_eff_sub;
    logic [31:0]           r1_spec_res;
    logic [FP32_EXP_W-1:0] r1_exp;
    logic [SIG_W-1:0]      r1_sig_x, r1_sig_y;
    logic                  r2_valid, r2_special, r2_sign;
    logic [31:0]           r2_spec_res;
    logic [FP32_EXP_W-1:0] r2_exp;
    logic [SUM_W-1:0]      r2_sum;
    logic                  r_out_valid;
    logic [31:0]           r_out;

    assign w_adv        = !(r_out_valid && !bus.out_ready);
    assign bus.in_ready = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.out      = r_out;

    // Subtraction is an addition of A and B with B's sign flipped.
    assign w_a      = bus.reg_A;
    assign w_bn     = {~bus.reg_B[31], bus.reg_B[30:0]};
    assign w_a_zero = fp32_is_zero(w_a);
    assign w_b_zero = fp32_is_zero(w_bn);
    assign w_a_ge   = w_a[30:0] >= w_bn[30:0];
    assign w_x      = w_a_ge ? w_a : w_bn;
    assign w_y      = w_a_ge ? w_bn : w_a;
    assign w_diff   = w_x.exp - w_y.exp;
    assign w_x_sig24 = {1'b1, w_x.man};
    assign w_y_sig24 = {1'b1, w_y.man};

`ifdef FPSUB_ROUND_EN
    logic [4:0]  w_sh;
    logic [49:0] w_wide;

    // Beyond 31 places every bit of Y lands in the sticky field anyway.
    assign w_sh    = (w_diff > 8'd31) ? 5'd31 : w_diff[4:0];
    assign w_wide  = {w_y_sig24, 26'b0} >> w_sh;
    assign w_sig_y = {w_wide[49:24], |w_wide[23:0]};
    assign w_sig_x = {w_x_sig24, 3'b000};
`else
    assign w_sig_y = w_y_sig24 >> w_diff;
    assign w_sig_x = w_x_sig24;
`endif

    assign w_sum = r1_eff_sub ? ({1'b0, r1_sig_x} - {1'b0, r1_sig_y})
                              : ({1'b0, r1_sig_x} + {1'b0, r1_sig_y});

    fpsub_normalize u_norm (
        .i_sum    (r2_sum),
        .i_exp    (r2_exp),
        .i_sign   (r2_sign),
        .o_result (w_norm)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_valid    <= 1'b0;
            r1_special  <= 1'b0;
            r1_sign     <= 1'b0;
            r1_eff_sub  <= 1'b0;
            r1_spec_res <= '0;
            r1_exp      <= '0;
            r1_sig_x    <= '0;
            r1_sig_y    <= '0;
            r2_valid    <= 1'b0;
            r2_special  <= 1'b0;
            r2_sign     <= 1'b0;
            r2_spec_res <= '0;
            r2_exp      <= '0;
            r2_sum      <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_adv) begin
            r1_valid    <= bus.in_valid;
            r1_special  <= w_a_zero | w_b_zero;
            r1_spec_res <= w_a_zero ? w_bn : w_a;
            r1_sign     <= w_x.sign;
            r1_eff_sub  <= w_a.sign ^ w_bn.sign;
            r1_exp      <= w_x.exp;
            r1_sig_x    <= w_sig_x;
            r1_sig_y    <= w_sig_y;
            r2_valid    <= r1_valid;
            r2_special  <= r1_special;
            r2_spec_res <= r1_spec_res;
            r2_sign     <= r1_sign;
            r2_exp      <= r1_exp;
            r2_sum      <= w_sum;
            r_out_valid <= r2_valid;
            r_out       <= r2_special ? r2_spec_res : w_norm;
        end
    end

endmodule

// File: tb/tb_fpsub_pipe.sv
// Directed-vector bench for fpsub_pipe: table of {A, B, expected}, a stalled
// stream, and a reset with requests in flight. Honors FPSUB_ROUND_EN.
module tb_fpsub_pipe;
    import fpsub_pipe_pkg::*;

    logic clk;
    logic reset;

    fpsub_pipe_if bus();

    fpsub_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        string       name;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef FPSUB_ROUND_EN
    localparam logic [31:0] RND_EXP = 32'h3F7F_FFFE;
`else
    localparam logic [31:0] RND_EXP = 32'h3F80_0000;
`endif
    localparam logic [31:0] ONE = {1'b0, 8'(FP32_BIAS), 23'd0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge after the result was consumed.
    task automatic run_one(input vec_t v);
        int lat;
        bus.in_valid  = 1'b1;
        bus.reg_A     = v.a;
        bus.reg_B     = v.b;
        bus.out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("[TB] vec %s A=%h B=%h out=%h lat=%0d", v.name, v.a, v.b, bus.out, lat);
        check({v.name, "_lat"}, 32'(lat), 32'd3);
        check({v.name, "_out"}, bus.out, v.exp_out);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          sent;
        int          recv;
        int          saw_block;
        int          extra;
        int          stale;
        logic        was_stall;
        logic [31:0] held;

        vecs[0]  = '{32'h4040_0000, ONE,          32'h4000_0000, "3m1"};
        vecs[1]  = '{ONE,          32'h4040_0000, 32'hC000_0000, "1m3"};
        vecs[2]  = '{ONE,          ONE,          32'h0000_0000, "cancel"};
        vecs[3]  = '{32'h0000_0000, 32'h4020_0000, 32'hC020_0000, "zero_a"};
        vecs[4]  = '{32'h4020_0000, 32'h0000_0000, 32'h4020_0000, "zero_b"};
        vecs[5]  = '{ONE,          32'hBF80_0000, 32'h4000_0000, "carry"};
        vecs[6]  = '{32'hC040_0000, ONE,          32'hC080_0000, "neg_add"};
        vecs[7]  = '{32'h8000_0000, 32'hC020_0000, 32'h4020_0000, "negzero_a"};
        vecs[8]  = '{32'h40A0_0000, 32'h4080_0000, ONE,          "lshift2"};
        vecs[9]  = '{32'hBF80_0000, 32'hBF80_0000, 32'h0000_0000, "neg_cancel"};
        vecs[10] = '{32'h4120_0000, 32'h3F00_0000, 32'h4118_0000, "align4"};
        vecs[11] = '{ONE,          32'h33C0_0000, RND_EXP,      "round_tie"};
        vecs[12] = '{32'h4000_0000, 32'hC000_0000, 32'h4080_0000, "2m_neg2"};
        vecs[13] = '{32'h3F80_0001, ONE,          32'h3400_0000, "lshift23"};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.reg_A     = '0;
        bus.reg_B     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out", bus.out, 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_one(vecs[i]);

        // Stream of 8 with the consumer stalled for 4 cycles mid-stream.
        sent = 0; recv = 0; saw_block = 0; was_stall = 1'b0; held = '0;
        for (int c = 0; c < 60 && recv < 8; c++) begin
            bus.out_ready = !(c >= 5 && c < 9);
            bus.in_valid  = (sent < 8);
            if (sent < 8) begin
                bus.reg_A = vecs[sent].a;
                bus.reg_B = vecs[sent].b;
            end
            #1;
            if (was_stall) begin
                check("stall_hold_out", bus.out, held);
                check("stall_hold_valid", 32'(bus.out_valid), 32'd1);
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                saw_block = 1;
            end else begin
                check("run_in_ready", 32'(bus.in_ready), 32'd1);
            end
            was_stall = bus.out_valid && !bus.out_ready;
            held      = bus.out;
            if (bus.in_valid && bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                $display("[TB] stream #%0d out=%h expect=%h", recv, bus.out, vecs[recv].exp_out);
                check("stream_out", bus.out, vecs[recv].exp_out);
                recv++;
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream_count", 32'(recv), 32'd8);
        check("stream_blocked", 32'(saw_block), 32'd1);
        extra = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        check("stream_no_dup", 32'(extra), 32'd0);

        // Reset with three requests in flight.
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.reg_A    = vecs[k + 3].a;
            bus.reg_B    = vecs[k + 3].b;
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        #1;
        $display("[TB] reset mid-flight out_valid=%0d out=%h", bus.out_valid, bus.out);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out", bus.out, 32'h0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        stale = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("no_stale_after_rst", 32'(stale), 32'd0);
        run_one(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
